mio_timer_array: RTL and testbench

//  Parametrised N-channel programmable timer/counter on the MIO peripheral bus; successor to the fixed 3-channel counter.

---
 rtl/mio_timer_array_pkg.sv | 37 +++
 rtl/mio_timer_array_if.sv | 13 +
 rtl/mio_timer_array_chan.sv | 124 ++++++++++++
 rtl/mio_timer_array.sv | 61 ++++++
 tb/tb_mio_timer_array.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mio_timer_array_pkg.sv
// Shared types and register layout for the MIO timer array.
// Register offsets, CTRL bit positions and the CTRL readback packing.
package mio_timer_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'b00,
    MODE_ONESHOT  = 2'b01,
    MODE_PERIODIC = 2'b10,
    MODE_PWM      = 2'b11
  } mode_e;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_LOAD  = 2'd1;
  localparam logic [1:0] REG_CMP   = 2'd2;
  localparam logic [1:0] REG_COUNT = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IE      = 3;
  localparam int CTRL_DONE    = 4;
  localparam int CTRL_PRE_LO  = 8;
  localparam int CTRL_PRE_HI  = 15;

  function automatic logic [31:0] ctrl_word(input logic en, input mode_e mode, input logic ie,
                                            input logic done, input logic [7:0] pre);
    logic [31:0] w;
    w                           = 32'd0;
    w[CTRL_EN]                  = en;
    w[CTRL_MODE_HI:CTRL_MODE_LO] = mode;
    w[CTRL_IE]                  = ie;
    w[CTRL_DONE]                = done;
    w[CTRL_PRE_HI:CTRL_PRE_LO]  = pre;
    return w;
  endfunction

endpackage

// File: rtl/mio_timer_array_if.sv
// MIO register bus seen by the timer array: one-cycle write/read strobes, registered rdata.
interface mio_timer_array_if #(
  parameter int ADDR_W = 6
);
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;

  modport master (output we, output re, output addr, output wdata, input rdata);
  modport slave  (input we, input re, input addr, input wdata, output rdata);
endinterface

// File: rtl/mio_timer_array_chan.sv
// One timer channel: prescaler, down-counter, CTRL/LOAD/CMP registers and waveform output.
module mio_timer_chan
  import mio_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic [3:0]       i_we_reg,
  input  logic [31:0]      i_wdata,
  output logic [3:0][31:0] o_rd,
  output logic             o_cnt_out,
  output logic             o_irq
);

  logic             r_en, r_ie, r_done, r_out;
  mode_e            r_mode;
  logic [7:0]       r_pre, r_psc;
  logic [CNT_W-1:0] r_load, r_cmp, r_count;

  logic             w_en_nx, w_ie_nx, w_done_nx, w_out_nx;
  mode_e            w_mode_nx;
  logic [7:0]       w_pre_nx, w_psc_nx;
  logic [CNT_W-1:0] w_load_nx, w_cmp_nx, w_count_nx, w_wval;
  logic             w_ctrl_we, w_run, w_tick, w_en_rise, w_term, w_unused_wdata;

  assign w_wval         = i_wdata[CNT_W-1:0];
  assign w_ctrl_we      = i_we_reg[REG_CTRL];
  assign w_run          = r_en && (r_mode != MODE_OFF);
  assign w_tick         = w_run && (r_psc == r_pre);
  assign w_en_rise      = w_ctrl_we && i_wdata[CTRL_EN] && !r_en;
  // A COUNT write in the same cycle swallows the tick, including a terminal one.
  assign w_term         = w_tick && !i_we_reg[REG_COUNT] && (r_count == {CNT_W{1'b0}});
  assign w_unused_wdata = ^i_wdata[7:5];

  // Next-state logic for all channel registers
  always_comb begin
    w_en_nx    = r_en;
    w_mode_nx  = r_mode;
    w_ie_nx    = r_ie;
    w_pre_nx   = r_pre;
    w_done_nx  = r_done;
    w_load_nx  = r_load;
    w_cmp_nx   = r_cmp;
    w_psc_nx   = r_psc;
    w_count_nx = r_count;
    w_out_nx   = r_out;

    if (w_ctrl_we) begin
      w_en_nx   = i_wdata[CTRL_EN];
      w_mode_nx = mode_e'(i_wdata[CTRL_MODE_HI:CTRL_MODE_LO]);
      w_ie_nx   = i_wdata[CTRL_IE];
      w_pre_nx  = i_wdata[CTRL_PRE_HI:CTRL_PRE_LO];
    end else if (w_term && (r_mode == MODE_ONESHOT)) begin
      w_en_nx = 1'b0;
    end else begin
      w_en_nx = r_en;
    end

    if (i_we_reg[REG_LOAD]) w_load_nx = w_wval;
    else                    w_load_nx = r_load;
    if (i_we_reg[REG_CMP])  w_cmp_nx = w_wval;
    else                    w_cmp_nx = r_cmp;

    if (w_term)                                 w_done_nx = 1'b1;
    else if (w_ctrl_we && i_wdata[CTRL_DONE])   w_done_nx = 1'b0;
    else                                        w_done_nx = r_done;

    if (w_en_rise || w_tick) w_psc_nx = 8'd0;
    else if (w_run)          w_psc_nx = r_psc + 8'd1;
    else                     w_psc_nx = r_psc;

    if (i_we_reg[REG_COUNT]) begin
      w_count_nx = w_wval;
    end else if (w_en_rise) begin
      w_count_nx = r_load;
    end else if (w_tick) begin
      if (r_count != {CNT_W{1'b0}})      w_count_nx = r_count - CNT_W'(1);
      else if (r_mode == MODE_ONESHOT)   w_count_nx = {CNT_W{1'b0}};
      else                               w_count_nx = r_load;
    end else begin
      w_count_nx = r_count;
    end

    // One-shot output follows EN, but only while the channel is or becomes enabled.
    if ((r_mode == MODE_PERIODIC) && w_term)                  w_out_nx = ~r_out;
    else if ((r_mode == MODE_PWM) && w_run)                   w_out_nx = (r_count < r_cmp);
    else if ((w_mode_nx == MODE_ONESHOT) && (r_en || w_en_nx)) w_out_nx = w_en_nx;
    else                                                      w_out_nx = r_out;
  end

  // Channel state registers
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      r_en    <= 1'b0;
      r_mode  <= MODE_OFF;
      r_ie    <= 1'b0;
      r_pre   <= 8'd0;
      r_done  <= 1'b0;
      r_load  <= {CNT_W{1'b0}};
      r_cmp   <= {CNT_W{1'b0}};
      r_psc   <= 8'd0;
      r_count <= {CNT_W{1'b0}};
      r_out   <= 1'b0;
    end else begin
      r_en    <= w_en_nx;
      r_mode  <= w_mode_nx;
      r_ie    <= w_ie_nx;
      r_pre   <= w_pre_nx;
      r_done  <= w_done_nx;
      r_load  <= w_load_nx;
      r_cmp   <= w_cmp_nx;
      r_psc   <= w_psc_nx;
      r_count <= w_count_nx;
      r_out   <= w_out_nx;
    end
  end

  assign o_rd      = {32'(r_count), 32'(r_cmp), 32'(r_load),
                      ctrl_word(r_en, r_mode, r_ie, r_done, r_pre)};
  assign o_cnt_out = r_out;
  assign o_irq     = r_done && r_ie;

endmodule

// File: rtl/mio_timer_array.sv
// N-channel programmable timer on the MIO bus: address decode, registered read mux, irq OR.
module mio_timer_array
  import mio_timer_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 6
) (
  input  logic               clk,
  input  logic               RSTN,
  mio_timer_array_if.slave   bus,
  output logic [NUM_CH-1:0]  cnt_out,
  output logic               irq
);

  localparam int CH_W = ADDR_W - 2;

  logic [CH_W-1:0]             w_ch;
  logic [1:0]                  w_reg;
  logic [NUM_CH-1:0][3:0][31:0] w_rd;
  logic [NUM_CH-1:0]           w_irq;
  logic [31:0]                 w_rsel;
  logic [31:0]                 r_rdata;

  assign w_ch  = bus.addr[ADDR_W-1:2];
  assign w_reg = bus.addr[1:0];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [3:0] w_we_reg;
    assign w_we_reg = (bus.we && (w_ch == CH_W'(g))) ? (4'b0001 << w_reg) : 4'b0000;

    mio_timer_chan #(.CNT_W(CNT_W)) u_chan (
      .clk       (clk),
      .RSTN      (RSTN),
      .i_we_reg  (w_we_reg),
      .i_wdata   (bus.wdata),
      .o_rd      (w_rd[g]),
      .o_cnt_out (cnt_out[g]),
      .o_irq     (w_irq[g])
    );
  end

  // Read mux; channel indices beyond NUM_CH match nothing and read 0
  always_comb begin
    w_rsel = 32'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_rsel = w_rsel | ((w_ch == CH_W'(c)) ? w_rd[c][w_reg] : 32'd0);
    end
  end

  // Registered read data, held while re is low
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN)       r_rdata <= 32'd0;
    else if (bus.re) r_rdata <= w_rsel;
    else             r_rdata <= r_rdata;
  end

  assign bus.rdata = r_rdata;
  assign irq       = |w_irq;

endmodule

// File: tb/tb_mio_timer_array.sv
// Self-checking bench for mio_timer_array: directed scenarios plus randomized channel runs
// checked against closed-form timing ((LOAD+1)*(PRE+1) per count cycle).
module tb_mio_timer_array;

  logic clk = 1'b0;
  logic RSTN;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mio_timer_array_if #(.ADDR_W(6)) bus_a ();
  mio_timer_array_if #(.ADDR_W(6)) bus_b ();
  logic [2:0]  cnt_a;
  logic        irq_a;
  logic [15:0] cnt_b;
  logic        irq_b;

  mio_timer_array #(.NUM_CH(3), .CNT_W(32), .ADDR_W(6)) dut_a (
    .clk(clk), .RSTN(RSTN), .bus(bus_a), .cnt_out(cnt_a), .irq(irq_a));
  mio_timer_array #(.NUM_CH(16), .CNT_W(8), .ADDR_W(6)) dut_b (
    .clk(clk), .RSTN(RSTN), .bus(bus_b), .cnt_out(cnt_b), .irq(irq_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctl(input int en, input int mode, input int ie,
                                     input int done, input int pre);
    return 32'((pre << 8) | (done << 4) | (ie << 3) | (mode << 1) | en);
  endfunction

  function automatic logic out_of(input int d, input int ch);
    if (d == 0) return cnt_a[ch];
    else        return cnt_b[ch];
  endfunction

  function automatic logic irq_of(input int d);
    return (d == 0) ? irq_a : irq_b;
  endfunction

  // All bus tasks start and end on a falling edge; the access lands on the posedge between.
  task automatic wr(input int d, input int ch, input int rg, input logic [31:0] data);
    if (d == 0) begin bus_a.we = 1'b1; bus_a.addr = 6'(ch * 4 + rg); bus_a.wdata = data; end
    else        begin bus_b.we = 1'b1; bus_b.addr = 6'(ch * 4 + rg); bus_b.wdata = data; end
    @(negedge clk);
    bus_a.we = 1'b0;
    bus_b.we = 1'b0;
  endtask

  task automatic rd(input int d, input int ch, input int rg, output logic [31:0] v);
    if (d == 0) begin bus_a.re = 1'b1; bus_a.addr = 6'(ch * 4 + rg); end
    else        begin bus_b.re = 1'b1; bus_b.addr = 6'(ch * 4 + rg); end
    @(negedge clk);
    bus_a.re = 1'b0;
    bus_b.re = 1'b0;
    v = (d == 0) ? bus_a.rdata : bus_b.rdata;
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    @(negedge clk);
    RSTN = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_toggle(input int d, input int ch, input int budget, output int t);
    logic prev;
    prev = out_of(d, ch);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_of(d, ch) !== prev) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic run_oneshot(input int d, input int ch, input int l, input int p);
    int t;
    logic [31:0] v;
    t = (l + 1) * (p + 1);
    wr(d, ch, 1, 32'(l));
    wr(d, ch, 0, ctl(1, 1, 1, 0, p));
    repeat (t - 1) @(negedge clk);
    check("oneshot_irq_early", irq_of(d), 1'b0);
    check("oneshot_out_high", out_of(d, ch), 1'b1);
    @(negedge clk);
    check("oneshot_irq", irq_of(d), 1'b1);
    check("oneshot_out_fall", out_of(d, ch), 1'b0);
    rd(d, ch, 0, v);
    check("oneshot_ctrl", v, ctl(0, 1, 1, 1, p));
    rd(d, ch, 3, v);
    check("oneshot_count0", v, 32'd0);
    wr(d, ch, 0, ctl(0, 1, 1, 1, p));
    check("oneshot_w1c", irq_of(d), 1'b0);
  endtask

  task automatic run_periodic(input int d, input int ch, input int l, input int p);
    int t, t0, t1, t2;
    t = (l + 1) * (p + 1);
    wr(d, ch, 1, 32'(l));
    wr(d, ch, 0, ctl(1, 2, 1, 0, p));
    t0 = cyc;
    wait_toggle(d, ch, 4 * t + 8, t1);
    check("per_first", 32'(t1 - t0), 32'(t));
    wait_toggle(d, ch, 4 * t + 8, t2);
    check("per_half", 32'(t2 - t1), 32'(t));
    check("per_irq", irq_of(d), 1'b1);
  endtask

  task automatic pwm_measure(input int ch, input int t, input int exp_hi, input string tag);
    int hi;
    hi = 0;
    repeat (2 * t + 2) @(negedge clk);
    for (int i = 0; i < t; i++) begin
      @(negedge clk);
      if (cnt_a[ch] === 1'b1) hi++;
    end
    check(tag, 32'(hi), 32'(exp_hi));
  endtask

  task automatic run_pwm(input int ch, input int l, input int p, input int cmp);
    int t;
    t = (l + 1) * (p + 1);
    wr(0, ch, 1, 32'(l));
    wr(0, ch, 2, 32'(cmp));
    wr(0, ch, 0, ctl(1, 3, 0, 0, p));
    pwm_measure(ch, t, ((cmp < l + 1) ? cmp : l + 1) * (p + 1), "pwm_high_cycles");
  endtask

  initial begin
    logic [31:0] v;
    int t1, t2, t3, t4, t5;
    RSTN = 1'b0;
    bus_a.we = 1'b0; bus_a.re = 1'b0; bus_a.addr = 6'd0; bus_a.wdata = 32'd0;
    bus_b.we = 1'b0; bus_b.re = 1'b0; bus_b.addr = 6'd0; bus_b.wdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_cnt_out", 32'(cnt_a), 32'd0);
    check("rst_irq", irq_a, 1'b0);
    check("rst_rdata", bus_a.rdata, 32'd0);
    RSTN = 1'b1;
    @(negedge clk);

    // Readback and read-data hold
    wr(0, 0, 1, 32'h1234);
    rd(0, 0, 1, v);
    check("load_readback", v, 32'h0000_1234);
    wr(0, 0, 1, 32'h5);
    repeat (2) @(negedge clk);
    check("rdata_hold", bus_a.rdata, 32'h0000_1234);

    // Mid-run reset abandons everything
    wr(0, 0, 1, 32'd0);
    wr(0, 0, 0, ctl(1, 2, 1, 0, 0));
    wr(0, 2, 2, 32'd7);
    repeat (3) @(negedge clk);
    check("pre_rst_irq", irq_a, 1'b1);
    #2 RSTN = 1'b0;
    #1;
    check("async_rst_cnt", 32'(cnt_a), 32'd0);
    check("async_rst_irq", irq_a, 1'b0);
    @(negedge clk);
    RSTN = 1'b1;
    @(negedge clk);
    rd(0, 0, 0, v); check("rst_ctrl0", v, 32'd0);
    rd(0, 0, 3, v); check("rst_count0", v, 32'd0);
    rd(0, 2, 2, v); check("rst_cmp2", v, 32'd0);

    // One-shot LOAD=3 PRE=0
    run_oneshot(0, 0, 3, 0);

    // Periodic LOAD=4 PRE=1 with a LOAD rewrite mid-run
    do_reset();
    run_periodic(0, 1, 4, 1);
    t2 = cyc;
    wr(0, 1, 1, 32'd1);
    wait_toggle(0, 1, 60, t3);
    check("per_pending_load", 32'(t3 - t2), 32'd10);
    wait_toggle(0, 1, 60, t4);
    check("per_new_half1", 32'(t4 - t3), 32'd4);
    wait_toggle(0, 1, 60, t5);
    check("per_new_half2", 32'(t5 - t4), 32'd4);

    // PWM LOAD=9 PRE=0, CMP changes take effect immediately
    do_reset();
    run_pwm(2, 9, 0, 3);
    wr(0, 2, 2, 32'd0);
    pwm_measure(2, 10, 0, "pwm_cmp0");
    wr(0, 2, 2, 32'd15);
    pwm_measure(2, 10, 10, "pwm_cmp15");

    // Terminal tick coincident with DONE write-one-to-clear
    do_reset();
    wr(0, 1, 1, 32'd2);
    wr(0, 1, 0, ctl(1, 2, 1, 0, 0));
    repeat (2) @(negedge clk);
    wr(0, 1, 0, ctl(1, 2, 1, 1, 0));
    check("done_beats_w1c", irq_a, 1'b1);

    // COUNT write coincident with a tick
    wr(0, 2, 1, 32'd100);
    wr(0, 2, 0, ctl(1, 2, 0, 0, 0));
    @(negedge clk);
    wr(0, 2, 3, 32'h55);
    rd(0, 2, 3, v);
    check("count_write_wins", v, 32'h55);

    // Channel index beyond NUM_CH
    wr(0, 0, 1, 32'h77);
    wr(0, 3, 1, 32'hDEAD);
    rd(0, 3, 1, v); check("ch3_read0", v, 32'd0);
    rd(0, 0, 1, v); check("ch3_no_alias", v, 32'h77);

    // Randomized channel runs
    for (int it = 0; it < 8; it++) begin
      int ch, md, l, p, cmp;
      ch  = int'($urandom_range(2, 0));
      md  = int'($urandom_range(3, 1));
      l   = int'($urandom_range(6, 0));
      p   = int'($urandom_range(2, 0));
      cmp = int'($urandom_range(9, 0));
      do_reset();
      case (md)
        1:       run_oneshot(0, ch, l, p);
        2:       run_periodic(0, ch, l, p);
        default: run_pwm(ch, l, p, cmp);
      endcase
    end

    // 16-channel, 8-bit variant
    do_reset();
    wr(1, 15, 1, 32'h1FF);
    rd(1, 15, 1, v);
    check("w8_load_trunc", v, 32'hFF);
    run_periodic(1, 15, 255, 0);
    do_reset();
    run_oneshot(1, 9, 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
